// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Sequences the PLL reset, qualifies the PLL lock and releases the
//            system reset. Build macro LOCK_LOSS_FILTER_EN debounces lock loss.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES         = 2,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock_i,
  output logic       pll_reset_o,
  output logic       sys_reset_o,
  output logic       ready_o,
  output logic [1:0] state_o,
  output logic [7:0] retry_count_o,
  output logic       lock_lost_o
);

  localparam int c_MAX_RS  = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int c_MAX_RST = (c_MAX_RS > LOCK_TIMEOUT_CYCLES) ? c_MAX_RS : LOCK_TIMEOUT_CYCLES;
`ifdef LOCK_LOSS_FILTER_EN
  localparam int c_MAX_ALL = (c_MAX_RST > LOSS_FILTER_CYCLES) ? c_MAX_RST : LOSS_FILTER_CYCLES;
`else
  localparam int c_MAX_ALL = c_MAX_RST;
`endif
  localparam int c_CNT_W = $clog2(c_MAX_ALL) + 1;

  localparam logic [c_CNT_W-1:0] c_RESET_LAST   = c_CNT_W'(RESET_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`ifdef LOCK_LOSS_FILTER_EN
  localparam logic [c_CNT_W-1:0] c_LOSS_LAST    = c_CNT_W'(LOSS_FILTER_CYCLES - 1);
`endif

  if (RESET_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 2 ||
      SYNC_STAGES < 2 || LOSS_FILTER_CYCLES < 1) begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STABLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 w_lock_s;
  logic                 w_fail;
  logic                 w_lost;

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  assign state_o  = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
    w_fail      = 1'b0;
    w_lost      = 1'b0;
    case (r_state)
      ST_RESET: begin
        if (r_cnt == c_RESET_LAST) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state_nxt = ST_RESET;
          w_fail      = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT;
        end else if (r_cnt == c_STABLE_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
`ifdef LOCK_LOSS_FILTER_EN
        // In RUN the counter tracks consecutive low cycles of the synced lock.
        if (w_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_LOSS_LAST) begin
          w_state_nxt = ST_RESET;
          w_fail      = 1'b1;
          w_lost      = 1'b1;
        end
`else
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt = ST_RESET;
          w_fail      = 1'b1;
          w_lost      = 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_RESET;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_sync  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], lock_i};
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_reset_o   <= 1'b1;
      sys_reset_o   <= 1'b1;
      ready_o       <= 1'b0;
      retry_count_o <= 8'd0;
      lock_lost_o   <= 1'b0;
    end else begin
      pll_reset_o <= (w_state_nxt == ST_RESET);
      sys_reset_o <= (w_state_nxt != ST_RUN);
      ready_o     <= (w_state_nxt == ST_RUN);
      lock_lost_o <= w_lost;
      if (w_fail && (retry_count_o != 8'hFF)) retry_count_o <= retry_count_o + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for pll_lock_supervisor: directed sequences plus randomized lock
// waveforms compared cycle by cycle with a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RESET_CYCLES        = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int SYNC_STAGES         = 2;
  localparam int LOSS_FILTER_CYCLES  = 4;
`ifdef LOCK_LOSS_FILTER_EN
  localparam int LOSS_N = LOSS_FILTER_CYCLES;
`else
  localparam int LOSS_N = 1;
`endif
  localparam int PERIOD = RESET_CYCLES + LOCK_TIMEOUT_CYCLES;

  logic       clkin  = 1'b0;
  logic       reset  = 1'b1;
  logic       lock_i = 1'b0;
  logic       pll_reset_o, sys_reset_o, ready_o, lock_lost_o;
  logic [1:0] state_o;
  logic [7:0] retry_count_o;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RESET_CYCLES        (RESET_CYCLES),
    .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .SYNC_STAGES         (SYNC_STAGES),
    .LOSS_FILTER_CYCLES  (LOSS_FILTER_CYCLES)
  ) dut (
    .clkin         (clkin),
    .reset         (reset),
    .lock_i        (lock_i),
    .pll_reset_o   (pll_reset_o),
    .sys_reset_o   (sys_reset_o),
    .ready_o       (ready_o),
    .state_o       (state_o),
    .retry_count_o (retry_count_o),
    .lock_lost_o   (lock_lost_o)
  );

  always #5 clkin = ~clkin;

  // Reference model: phase 0..3, cycles elapsed in the phase, low run in RUN.
  int m_phase, m_age, m_lows, m_retry;
  bit m_lost;
  bit m_pipe[$];

  function automatic void model_reset();
    m_phase = 0; m_age = 0; m_lows = 0; m_retry = 0; m_lost = 1'b0;
    m_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
  endfunction

  function automatic void m_enter(input int p);
    m_phase = p; m_age = 0; m_lows = 0;
  endfunction

  function automatic void m_retry_bump();
    if (m_retry < 255) m_retry++;
  endfunction

  function automatic void model_edge(input bit l);
    bit s;
    s = m_pipe.pop_front();
    m_pipe.push_back(l);
    m_lost = 1'b0;
    case (m_phase)
      0: begin
        m_age++;
        if (m_age == RESET_CYCLES) m_enter(1);
      end
      1: begin
        m_age++;
        if (s) m_enter(2);
        else if (m_age == LOCK_TIMEOUT_CYCLES) begin m_retry_bump(); m_enter(0); end
      end
      2: begin
        if (!s) m_enter(1);
        else begin
          m_age++;
          if (m_age == LOCK_STABLE_CYCLES) m_enter(3);
        end
      end
      default: begin
        m_lows = s ? 0 : m_lows + 1;
        if (m_lows == LOSS_N) begin m_lost = 1'b1; m_retry_bump(); m_enter(0); end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pll_reset_o",   32'(pll_reset_o),   32'(m_phase == 0));
    chk("sys_reset_o",   32'(sys_reset_o),   32'(m_phase != 3));
    chk("ready_o",       32'(ready_o),       32'(m_phase == 3));
    chk("state_o",       32'(state_o),       32'(m_phase));
    chk("retry_count_o", 32'(retry_count_o), 32'(m_retry));
    chk("lock_lost_o",   32'(lock_lost_o),   32'(m_lost));
  endtask

  // Drive lock_i for one cycle, advance the model on the edge, compare after it.
  task automatic step(input bit l);
    lock_i = l;
    @(posedge clkin);
    model_edge(l);
    #1;
    compare_all();
  endtask

  // Called 1 ns after an edge: asserts reset mid-cycle and checks the outputs
  // before any further clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("async_pll_reset", 32'(pll_reset_o),   32'd1);
    chk("async_sys_reset", 32'(sys_reset_o),   32'd1);
    chk("async_ready",     32'(ready_o),       32'd0);
    chk("async_state",     32'(state_o),       32'd0);
    chk("async_retry",     32'(retry_count_o), 32'd0);
    chk("async_lost",      32'(lock_lost_o),   32'd0);
    model_reset();
    @(posedge clkin);
    @(posedge clkin);
    #1 reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st);
    int found;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step(1'b1);
      if (state_o == st) found = 1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    bit lv;
    int run;
    model_reset();
    @(posedge clkin);
    #1;
    chk("rst_pll_reset", 32'(pll_reset_o), 32'd1);
    chk("rst_sys_reset", 32'(sys_reset_o), 32'd1);
    chk("rst_ready",     32'(ready_o),     32'd0);
    compare_all();
    @(posedge clkin);
    #1 reset = 1'b0;

    // Lock arrives at cycle 10; sequence runs through to RUN.
    for (int i = 0; i < 24; i++) begin
      step(i >= 10);
      if (i == 2)  chk("t1_pll_high_c2", 32'(pll_reset_o), 32'd1);
      if (i == 3)  chk("t1_pll_low_c3",  32'(pll_reset_o), 32'd0);
      if (i == 11) chk("t1_wait",        32'(state_o),     32'd1);
      if (i == 12) chk("t1_stable",      32'(state_o),     32'd2);
      if (i == 19) chk("t1_not_ready",   32'(ready_o),     32'd0);
      if (i == 20) chk("t1_ready",       32'(ready_o),     32'd1);
      if (i == 20) chk("t1_sys_release", 32'(sys_reset_o), 32'd0);
    end
    chk("t1_retry", 32'(retry_count_o), 32'd0);

    // Lock dropouts while in RUN.
`ifdef LOCK_LOSS_FILTER_EN
    for (int len = 1; len < LOSS_N; len++) begin
      for (int j = 0; j < len + 6; j++) step(j >= len);
      chk("t4_short_dropout_ignored", 32'(ready_o), 32'd1);
    end
`endif
    for (int j = 0; j < 14; j++) begin
      step(j >= LOSS_N);
      if (j == LOSS_N)     chk("t4_no_loss_yet", 32'(lock_lost_o), 32'd0);
      if (j == LOSS_N + 1) chk("t4_lost_pulse",  32'(lock_lost_o), 32'd1);
      if (j == LOSS_N + 1) chk("t4_ready_drop",  32'(ready_o),     32'd0);
      if (j == LOSS_N + 1) chk("t4_sys_reset",   32'(sys_reset_o), 32'd1);
      if (j == LOSS_N + 1) chk("t4_retry",       32'(retry_count_o), 32'd1);
      if (j == LOSS_N + 2) chk("t4_lost_end",    32'(lock_lost_o), 32'd0);
      if (j == LOSS_N + 4) chk("t4_pll_high",    32'(pll_reset_o), 32'd1);
      if (j == LOSS_N + 5) chk("t4_pll_low",     32'(pll_reset_o), 32'd0);
    end

    // One-cycle dip in STABLE after five synced-high cycles.
    do_reset();
    wait_state("t3_reach_stable", 2'd2);
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    for (int j = 1; j < 14; j++) begin
      step(1'b1);
      if (j == 2)  chk("t3_back_to_wait", 32'(state_o), 32'd1);
      if (j == 3)  chk("t3_stable_again", 32'(state_o), 32'd2);
      if (j == 10) chk("t3_not_ready",    32'(ready_o), 32'd0);
      if (j == 11) chk("t3_ready",        32'(ready_o), 32'd1);
    end
    chk("t3_no_retry", 32'(retry_count_o), 32'd0);

    // Asynchronous reset mid-STABLE and mid-RUN.
    do_reset();
    wait_state("t5_reach_stable", 2'd2);
    step(1'b1);
    do_reset();
    wait_state("t5_reach_run", 2'd3);
    do_reset();
    for (int j = 0; j < 6; j++) begin
      step(1'b0);
      if (j == 2) chk("t5_pll_high", 32'(pll_reset_o), 32'd1);
      if (j == 3) chk("t5_pll_low",  32'(pll_reset_o), 32'd0);
    end

    // Lock never arrives: periodic retries and saturation of the retry count.
    do_reset();
    for (int i = 0; i < 300 * PERIOD; i++) begin
      step(1'b0);
      if (i == 3)                chk("t2_wait",        32'(state_o), 32'd1);
      if (i == PERIOD - 2)       chk("t2_retry0",      32'(retry_count_o), 32'd0);
      if (i == PERIOD - 1)       chk("t2_retry1",      32'(retry_count_o), 32'd1);
      if (i == PERIOD - 1)       chk("t2_reset_state", 32'(state_o), 32'd0);
      if (i == PERIOD + 3)       chk("t2_wait_again",  32'(state_o), 32'd1);
      if (i == 2 * PERIOD - 1)   chk("t2_retry2",      32'(retry_count_o), 32'd2);
      if (i == 2 * PERIOD + 2)   chk("t2_pll_pulse",   32'(pll_reset_o), 32'd1);
      if (i == 2 * PERIOD + 3)   chk("t2_pll_end",     32'(pll_reset_o), 32'd0);
      if (i == 3 * PERIOD - 1)   chk("t2_retry3",      32'(retry_count_o), 32'd3);
      if (i == 255 * PERIOD - 2) chk("t6_retry254",    32'(retry_count_o), 32'd254);
      if (i == 255 * PERIOD - 1) chk("t6_retry255",    32'(retry_count_o), 32'd255);
      if (i == 300 * PERIOD - 1) chk("t6_still_retry", 32'(state_o), 32'd0);
    end
    chk("t6_saturated", 32'(retry_count_o), 32'd255);

    // Randomized lock waveforms with occasional resets.
    do_reset();
    run = 0;
    lv  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lv = ($urandom_range(0, 3) != 0);
        if (lv) run = $urandom_range(1, 60);
        else if ($urandom_range(0, 7) == 0) run = $urandom_range(30, 50);
        else run = $urandom_range(1, 6);
      end
      step(lv);
      run--;
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
